lut_interp: RTL and testbench

Linear-interpolating table reader that sits directly downstream of the dual-port lookup RAM in the predistortion path. It takes a stream of unsigned table indices with fractional bits, drives one RAM port, and consumes the RAM's current-entry and next-entry read data. It outputs `a + (b - a) * frac` as a backpressured stream at one sample per clock.

---
 rtl/lut_interp_pkg.sv | 10 +
 rtl/lut_interp_mac.sv | 49 ++++
 rtl/lut_interp.sv | 74 +++++++
 tb/tb_lut_interp.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_interp_pkg.sv
// Shared widths and pipeline depth for the linear-interpolating table reader.
// The surrounding delay-matching logic uses LUT_INTERP_LATENCY.
package lut_interp_pkg;

    localparam int LUT_DWIDTH         = 16;
    localparam int LUT_AWIDTH         = 9;
    localparam int LUT_FWIDTH         = 7;
    localparam int LUT_INTERP_LATENCY = 3;

endpackage

// File: rtl/lut_interp_mac.sv
// Interpolation datapath: registered (b - a) * frac, then a + (prod >>> FWIDTH).
// This block holds data only; valid and last tracking lives in lut_interp.
module lut_interp_mac
    import lut_interp_pkg::*;
#(
    parameter int DWIDTH = LUT_DWIDTH,
    parameter int FWIDTH = LUT_FWIDTH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     en,
    input  logic signed [DWIDTH-1:0] ram_do,
    input  logic signed [DWIDTH-1:0] ram_do_next,
    input  logic        [FWIDTH-1:0] frac,
    output logic signed [DWIDTH-1:0] result
);

    localparam int PW = DWIDTH + FWIDTH + 2;

    logic signed [DWIDTH:0]   diff;
    logic signed [FWIDTH:0]   frac_s;
    logic signed [PW-1:0]     prod;
    logic signed [PW-1:0]     prod2;
    logic signed [PW-1:0]     shifted;
    logic signed [PW-1:0]     sum;
    logic signed [DWIDTH-1:0] a2;

    // One extra bit keeps b - a exact across the full signed entry range.
    assign diff    = {ram_do_next[DWIDTH-1], ram_do_next} - {ram_do[DWIDTH-1], ram_do};
    assign frac_s  = {1'b0, frac};
    assign prod    = PW'(diff) * PW'(frac_s);
    assign shifted = prod2 >>> FWIDTH;
    assign sum     = PW'(a2) + shifted;

    // NOTE: the interpolated value always lies between a and b, so keeping
    // only the low DWIDTH bits of sum never loses information.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod2  <= '0;
            a2     <= '0;
            result <= '0;
        end else if (en) begin
            prod2  <= prod;
            a2     <= ram_do;
            result <= sum[DWIDTH-1:0];
        end
    end

endmodule

// File: rtl/lut_interp.sv
// Linear-interpolating reader behind the dual-port lookup RAM: one sample per
// clock, three register stages, a single global advance enable for backpressure.
module lut_interp
    import lut_interp_pkg::*;
#(
    parameter int DWIDTH = LUT_DWIDTH,
    parameter int AWIDTH = LUT_AWIDTH,
    parameter int FWIDTH = LUT_FWIDTH
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [AWIDTH+FWIDTH-1:0]   i_tdata,
    input  logic                       i_tlast,
    input  logic                       i_tvalid,
    output logic                       i_tready,
    output logic signed [DWIDTH-1:0]   o_tdata,
    output logic                       o_tlast,
    output logic                       o_tvalid,
    input  logic                       o_tready,
    output logic                       ram_en,
    output logic [AWIDTH-1:0]          ram_addr,
    input  logic signed [DWIDTH-1:0]   ram_do,
    input  logic signed [DWIDTH-1:0]   ram_do_next
);

    logic              adv;
    logic              v1;
    logic              v2;
    logic              last1;
    logic              last2;
    logic [FWIDTH-1:0] frac1;

    // The RAM output registers are stage 0, so gating ram_en with adv freezes them in a stall.
    assign adv      = !o_tvalid || o_tready;
    assign i_tready = adv;
    assign ram_en   = adv;
    assign ram_addr = i_tdata[AWIDTH+FWIDTH-1:FWIDTH];

    // NOTE: bubbles advance like samples (v1 <= i_tvalid), so a gap at the
    // input reappears as the same gap at the output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            last1    <= 1'b0;
            last2    <= 1'b0;
            frac1    <= '0;
            o_tvalid <= 1'b0;
            o_tlast  <= 1'b0;
        end else if (adv) begin
            v1       <= i_tvalid;
            frac1    <= i_tdata[FWIDTH-1:0];
            last1    <= i_tlast;
            v2       <= v1;
            last2    <= last1;
            o_tvalid <= v2;
            o_tlast  <= last2;
        end
    end

    lut_interp_mac #(
        .DWIDTH (DWIDTH),
        .FWIDTH (FWIDTH)
    ) u_mac (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (adv),
        .ram_do      (ram_do),
        .ram_do_next (ram_do_next),
        .frac        (frac1),
        .result      (o_tdata)
    );

endmodule

// File: tb/tb_lut_interp.sv
// Scoreboard bench for lut_interp: a behavioural RAM and an arithmetic reference
// model feed expectations into a queue that a free-running monitor drains.
module tb_lut_interp;
    import lut_interp_pkg::*;

    localparam int DW = 16;
    localparam int AW = 9;
    localparam int FW = 7;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        logic signed [DW-1:0] data;
        logic                 last;
        int                   acc_cyc;
        bit                   lat;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [AW+FW-1:0]     i_tdata = '0;
    logic                 i_tlast = 1'b0;
    logic                 i_tvalid = 1'b0;
    logic                 i_tready;
    logic signed [DW-1:0] o_tdata;
    logic                 o_tlast;
    logic                 o_tvalid;
    logic                 o_tready = 1'b1;
    logic                 ram_en;
    logic [AW-1:0]        ram_addr;
    logic signed [DW-1:0] ram_do = '0;
    logic signed [DW-1:0] ram_do_next = '0;

    logic signed [DW-1:0] lut_mem [0:DEPTH-1];
    exp_t                 exp_q[$];
    int                   out_cycles[$];
    int                   cyc = 0;
    int                   n_checks = 0;
    int                   n_fail = 0;
    bit                   rdy_rand = 1'b0;

    lut_interp dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_tdata     (i_tdata),
        .i_tlast     (i_tlast),
        .i_tvalid    (i_tvalid),
        .i_tready    (i_tready),
        .o_tdata     (o_tdata),
        .o_tlast     (o_tlast),
        .o_tvalid    (o_tvalid),
        .o_tready    (o_tready),
        .ram_en      (ram_en),
        .ram_addr    (ram_addr),
        .ram_do      (ram_do),
        .ram_do_next (ram_do_next)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: registered read of entry and entry+1, next clamped at the top.
    always @(posedge clk) begin
        if (ram_en) begin
            ram_do      <= lut_mem[ram_addr];
            ram_do_next <= (ram_addr == AW'(DEPTH - 1)) ? lut_mem[ram_addr] : lut_mem[int'(ram_addr) + 1];
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // a + floor((b - a) * frac / 2^FW), wrapped to the signed output width.
    function automatic logic signed [DW-1:0] ref_interp(input int idx, input int frac);
        int a, b, d, q;
        a = int'(lut_mem[idx]);
        b = (idx == DEPTH - 1) ? a : int'(lut_mem[idx + 1]);
        d = (b - a) * frac;
        q = (d >= 0) ? d / (1 << FW) : -((-d + (1 << FW) - 1) / (1 << FW));
        return DW'(a + q);
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            o_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: handshake rule, stall stability and scoreboard compare.
    initial begin
        exp_t                 e;
        bit                   prev_stall = 1'b0;
        logic signed [DW-1:0] prev_data = '0;
        logic                 prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_stall = 1'b0;
            end else begin
                check("i_tready_rule", longint'(i_tready), longint'(!o_tvalid || o_tready));
                check("ram_en_rule", longint'(ram_en), longint'(!o_tvalid || o_tready));
                if (prev_stall) begin
                    check("stall_valid", longint'(o_tvalid), 1);
                    check("stall_data", longint'(o_tdata), longint'(prev_data));
                    check("stall_last", longint'(o_tlast), longint'(prev_last));
                end
                if (o_tvalid && o_tready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", longint'(o_tdata), -99999);
                    end else begin
                        e = exp_q.pop_front();
                        check("data", longint'(o_tdata), longint'(e.data));
                        check("last", longint'(o_tlast), longint'(e.last));
                        // Output register loads on the third advancing edge, counting the acceptance edge.
                        if (e.lat) check("latency", longint'(cyc - e.acc_cyc), longint'(LUT_INTERP_LATENCY - 1));
                        out_cycles.push_back(cyc);
                    end
                end
                prev_stall = o_tvalid && !o_tready;
                prev_data  = o_tdata;
                prev_last  = o_tlast;
            end
        end
    end

    task automatic send(input int idx, input int frac, input bit last, input bit lat);
        exp_t e;
        bit   acc = 1'b0;
        int   budget = 0;
        i_tdata  = {idx[AW-1:0], frac[FW-1:0]};
        i_tlast  = last;
        i_tvalid = 1'b1;
        while (!acc && budget < 1000) begin
            @(negedge clk);
            acc = i_tready;
            if (acc) begin
                e.data    = ref_interp(idx, frac);
                e.last    = last;
                e.acc_cyc = cyc + 1;
                e.lat     = lat;
                exp_q.push_back(e);
            end
            @(posedge clk);
            #1;
            budget++;
        end
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int b = 0;
        while (exp_q.size() != 0 && b < 2000) begin
            @(negedge clk);
            b++;
        end
        if (exp_q.size() != 0) check("drain_timeout", longint'(exp_q.size()), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) lut_mem[i] = DW'(256 * i);

        // Reset state, while held and just after release.
        repeat (2) @(negedge clk);
        check("rst_o_tdata", longint'(o_tdata), 0);
        check("rst_o_tvalid", longint'(o_tvalid), 0);
        check("rst_o_tlast", longint'(o_tlast), 0);
        check("rst_i_tready", longint'(i_tready), 1);
        check("rst_ram_en", longint'(ram_en), 1);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Rising slope with latency.
        send(5, 64, 1'b0, 1'b1);
        idle(1);
        drain();

        // Negative slope and floor truncation.
        lut_mem[10] = 16'sd1000;
        lut_mem[11] = -16'sd1000;
        send(10, 32, 1'b0, 1'b1);
        send(10, 1, 1'b1, 1'b0);
        idle(1);
        drain();
        lut_mem[10] = DW'(256 * 10);
        lut_mem[11] = DW'(256 * 11);

        // Top entry clamps instead of wrapping.
        send(DEPTH - 1, 127, 1'b0, 1'b0);
        send(DEPTH - 1, 0, 1'b0, 1'b0);
        send(DEPTH - 2, 100, 1'b0, 1'b0);
        idle(1);
        drain();

        // Backpressure: ordered stream under random o_tready.
        rdy_rand = 1'b1;
        for (int i = 0; i < 32; i++) send(i, 0, i == 31, 1'b0);
        idle(1);
        drain();
        rdy_rand = 1'b0;
        idle(2);

        // Full rate: 100 back-to-back outputs, last only on the final one.
        out_cycles.delete();
        for (int i = 0; i < 100; i++)
            send(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, (1 << FW) - 1)), i == 99, 1'b1);
        idle(1);
        drain();
        check("fullrate_count", longint'(out_cycles.size()), 100);
        if (out_cycles.size() == 100) check("fullrate_span", longint'(out_cycles[99] - out_cycles[0]), 99);

        // A 2-cycle input gap gives a 2-cycle output gap.
        out_cycles.delete();
        send(20, 5, 1'b0, 1'b0);
        idle(2);
        send(21, 6, 1'b1, 1'b0);
        idle(1);
        drain();
        check("gap_count", longint'(out_cycles.size()), 2);
        if (out_cycles.size() == 2) check("gap_span", longint'(out_cycles[1] - out_cycles[0]), 3);

        // Reset with three samples in flight: they must vanish.
        send(100, 0, 1'b0, 1'b0);
        send(101, 0, 1'b0, 1'b0);
        send(102, 0, 1'b1, 1'b0);
        i_tvalid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("midrst_o_tvalid", longint'(o_tvalid), 0);
        check("midrst_o_tdata", longint'(o_tdata), 0);
        check("midrst_o_tlast", longint'(o_tlast), 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        send(77, 10, 1'b1, 1'b1);
        idle(1);
        drain();

        // Random samples under random backpressure.
        rdy_rand = 1'b1;
        for (int i = 0; i < 150; i++)
            send(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, (1 << FW) - 1)),
                 1'($urandom_range(0, 1)), 1'b0);
        idle(1);
        drain();
        rdy_rand = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
